// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: special-register
// addresses, FSM state encoding and source-count constants.
// Latency: n/a (declarations only). Backpressure: n/a.
package irq_ctrl_pkg;

   // Number of peripheral interrupt sources and the width of a source id.
   localparam int NUM_SRC = 8;
   localparam int SRC_W   = 3;

   // Special-register addresses as seen on sr_sel.
   localparam logic [15:0] SR_MASK = 16'h0040;
   localparam logic [15:0] SR_PEND = 16'h0041;
   localparam logic [15:0] SR_SRC  = 16'h0042;
   localparam logic [15:0] SR_MODE = 16'h0043;

   // Controller state: waiting for work, requesting the CPU, CPU in handler.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_e;

   // 8-bit registers read back zero-extended onto the 16-bit SR bus.
   function automatic logic [15:0] sr_zext(input logic [NUM_SRC-1:0] v);
      return {{(16-NUM_SRC){1'b0}}, v};
   endfunction

endpackage

// File: rtl/irq_ctrl_arb.sv
// Source selector: picks the first requesting id searching upward from
// start_i and wrapping modulo NUM_SRC. start_i = 0 gives fixed priority.
// Latency: combinational. Backpressure: none.
// Ports: req_i request vector, start_i search origin -> vld_o any request,
//        id_o selected id (0 when vld_o is low).
module irq_arb
   import irq_ctrl_pkg::*;
(
   input  logic [NUM_SRC-1:0] req_i,
   input  logic [SRC_W-1:0]   start_i,
   output logic               vld_o,
   output logic [SRC_W-1:0]   id_o
);

   logic [SRC_W-1:0] idx;

   // Walk offsets from farthest to nearest so the nearest hit to start_i
   // is the last assignment and therefore wins.
   always_comb begin
      vld_o = 1'b0;
      id_o  = '0;
      idx   = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         idx = start_i + SRC_W'(i);
         if (req_i[idx]) begin
            vld_o = 1'b1;
            id_o  = idx;
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: 8 edge/level sources, mask/pending/mode registers on
// the SR bus, single outstanding request to the CPU with ack/eoi handshake.
// Latency: irq_src edge -> PEND +1 cycle -> irq_out +2 cycles. Backpressure:
// one interrupt in flight; new sources wait in PEND until after eoi.
// Build option: IRQ_CTRL_RR_EN selects round-robin arbitration (default fixed).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   irq_src[7:0]      peripheral interrupt lines (bit 0 highest fixed priority)
//   sr_sel/sr_in/sr_ie special-register select, write data, write enable
//   sr_out[15:0]      combinational read data, 0 for unmapped selects
//   irq_en            CPU interrupt enable; irq_out interrupt request
//   irq_ack, eoi      CPU vector pulse / end-of-interrupt pulse
//   cur_src, busy     id in service; high while requesting or servicing
module irq_ctrl
   import irq_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_SRC-1:0]  irq_src,
   input  logic [15:0]         sr_sel,
   input  logic [15:0]         sr_in,
   input  logic                sr_ie,
   output logic [15:0]         sr_out,
   input  logic                irq_en,
   output logic                irq_out,
   input  logic                irq_ack,
   input  logic                eoi,
   output logic [SRC_W-1:0]    cur_src,
   output logic                busy
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [NUM_SRC-1:0] mask_q;
   logic [NUM_SRC-1:0] mode_q;
   logic [NUM_SRC-1:0] pend_q;
   logic [NUM_SRC-1:0] pend_d;
   logic [NUM_SRC-1:0] src_q;      // delayed copy of irq_src for edge detect
   irq_state_e         state_q;
   logic [SRC_W-1:0]   cur_src_q;
   logic               irq_out_q;
   logic               busy_q;

   logic               wr_mask;
   logic               wr_pend;
   logic               wr_mode;
   logic [NUM_SRC-1:0] pend_rise;
   logic [NUM_SRC-1:0] pend_clr;
   logic               req_abort;
   logic               req_take;
   logic               arb_vld;
   logic [SRC_W-1:0]   arb_id;
   logic [SRC_W-1:0]   arb_start;

   // Registers are 8 bits wide; the upper half of the write bus is ignored.
   logic               sr_in_unused;
   assign sr_in_unused = ^sr_in[15:NUM_SRC];

   assign wr_mask = sr_ie && (sr_sel == SR_MASK);
   assign wr_pend = sr_ie && (sr_sel == SR_PEND);
   assign wr_mode = sr_ie && (sr_sel == SR_MODE);

   // A pending request is withdrawn if the CPU disables interrupts or the
   // source gets masked before the CPU vectors; abort beats a same-cycle ack.
   assign req_abort = (state_q == ST_REQ) && (!irq_en || !mask_q[cur_src_q]);
   assign req_take  = (state_q == ST_REQ) && !req_abort && irq_ack;

   // ------------------------------------------------------------------
   // Configuration registers and edge-detect delay
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q <= '0;
         mode_q <= '0;
         src_q  <= '0;
         pend_q <= '0;
      end else begin
         if (wr_mask) mask_q <= sr_in[NUM_SRC-1:0];
         if (wr_mode) mode_q <= sr_in[NUM_SRC-1:0];
         src_q  <= irq_src;
         pend_q <= pend_d;
      end
   end

   // ------------------------------------------------------------------
   // Pending next state
   //   edge bits: set on rising edge, cleared by write-1 or by the ack of
   //              that source; a same-cycle set overrides any clear.
   //   level bits: simply track the input, so writes and acks do nothing.
   // ------------------------------------------------------------------
   always_comb begin
      pend_clr = '0;
      if (wr_pend) pend_clr = sr_in[NUM_SRC-1:0];
      if (req_take) pend_clr[cur_src_q] = 1'b1;
      pend_rise = irq_src & ~src_q;
      pend_d    = (mode_q & ((pend_q & ~pend_clr) | pend_rise))
                | (~mode_q & irq_src);
   end

   // ------------------------------------------------------------------
   // Arbitration origin
   // ------------------------------------------------------------------
`ifdef IRQ_CTRL_RR_EN
   // Next search starts one past the last source the CPU accepted.
   logic [SRC_W-1:0] rr_ptr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else if (req_take) begin
         rr_ptr_q <= cur_src_q + SRC_W'(1);
      end
   end

   assign arb_start = rr_ptr_q;
`else
   assign arb_start = '0;
`endif

   irq_arb u_arb (
      .req_i   (pend_q & mask_q),
      .start_i (arb_start),
      .vld_o   (arb_vld),
      .id_o    (arb_id)
   );

   // ------------------------------------------------------------------
   // Request/service FSM with registered outputs. irq_out is high exactly
   // while in REQ; busy is high in REQ and SERVICE.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cur_src_q <= '0;
         irq_out_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (irq_en && arb_vld) begin
                  state_q   <= ST_REQ;
                  cur_src_q <= arb_id;
                  irq_out_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            ST_REQ: begin
               if (req_abort) begin
                  state_q   <= ST_IDLE;
                  irq_out_q <= 1'b0;
                  busy_q    <= 1'b0;
               end else if (irq_ack) begin
                  state_q   <= ST_SERVICE;
                  irq_out_q <= 1'b0;
               end
            end
            ST_SERVICE: begin
               // No nesting: everything else waits in PEND until eoi.
               if (eoi) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               irq_out_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign irq_out = irq_out_q;
   assign busy    = busy_q;
   assign cur_src = cur_src_q;

   // ------------------------------------------------------------------
   // Special-register read mux
   // ------------------------------------------------------------------
   always_comb begin
      sr_out = '0;
      case (sr_sel)
         SR_MASK: sr_out = sr_zext(mask_q);
         SR_PEND: sr_out = sr_zext(pend_q);
         SR_SRC:  sr_out = {busy_q, {(16-1-SRC_W){1'b0}}, cur_src_q};
         SR_MODE: sr_out = sr_zext(mode_q);
         default: sr_out = '0;
      endcase
   end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have irq_src  in  8  peripheral interrupt lines, synchronous to clk; bit 0 is the highest fixed priority.
REQ-003 SHALL have sr_sel  in  16  special-register select; sr_in  in  16  write data; sr_ie  in  1  write enable.
REQ-004 SHALL have sr_out  out  16  combinational read data; 0 when sr_sel does not select a register of this block.
REQ-005 SHALL have irq_en  in  1  CPU interrupt-enable flag; irq_out  out  1  interrupt request to the CPU.
REQ-006 SHALL have irq_ack  in  1  one-cycle pulse when the CPU vectors to the handler; eoi  in  1  one-cycle end-of-interrupt pulse (iret).
REQ-007 SHALL have cur_src  out  3  id of the source in service; busy  out  1  high in REQ or SERVICE.

Function
REQ-008 Registers: MASK at sel 0x40 (R/W, 8b, 1 = enabled); PEND at 0x41 (R, write-1-to-clear, 8b); SRC at 0x42 (R, {busy, 12'b0, cur_src}); MODE at 0x43 (R/W, 8b, 1 = edge, 0 = level).
REQ-009 Upper bits of sr_in SHALL be ignored on writes, and reads SHALL zero-extend to 16 bits.
REQ-010 Edge mode: a PEND bit SHALL set on the cycle after a 0->1 transition of irq_src, detected against a one-register delayed copy.
REQ-011 Level mode: a PEND bit SHALL equal the registered irq_src bit, and writes to that bit SHALL have no effect.
REQ-012 Same-cycle set and write-1-clear of one PEND bit: set SHALL win.
REQ-013 FSM states: IDLE, REQ, SERVICE.
REQ-014 IDLE->REQ when irq_en=1 and (PEND & MASK) != 0; cur_src latches the winner; irq_out=1 from the next cycle.
REQ-015 REQ->SERVICE on irq_ack; irq_out drops the same edge; the edge-mode PEND bit of cur_src clears.
REQ-016 REQ->IDLE without service if irq_en=0 or the MASK bit of cur_src=0 before ack; irq_out drops, PEND is kept.
REQ-017 SERVICE->IDLE on eoi; the next arbitration can assert irq_out no earlier than 2 cycles after eoi.
REQ-018 eoi in IDLE/REQ and irq_ack in IDLE/SERVICE SHALL be ignored.
REQ-019 Sources pending during SERVICE SHALL remain in PEND, with no nesting.
REQ-020 Latency from an irq_src edge to irq_out high SHALL be 2 cycles when IDLE and irq_en=1.

Reset
REQ-021 rst SHALL clear MASK, PEND, MODE, the edge-detect registers, cur_src, busy, and irq_out, and force IDLE.
REQ-022 rst mid-REQ or mid-SERVICE SHALL abort at once; irq_out=0 is visible asynchronously.

Configuration
REQ-023 With IRQ_CTRL_RR_EN defined, arbitration SHALL be round-robin: search starts at last-serviced id+1 mod 8; the pointer updates on REQ->SERVICE and resets to 0.
REQ-024 Without IRQ_CTRL_RR_EN, arbitration SHALL be fixed priority (lowest index wins), with no pointer register.

Structure
REQ-025 A shared package SHALL hold the SR addresses (0x40-0x43), the FSM state encoding, and the source count constant (8).
REQ-026 The priority/round-robin selector SHALL be a sub-module irq_arb (request vector, start pointer -> valid, 3-bit id).

Verification
REQ-027 MODE=0xFF, MASK=0x01, irq_en=1, pulse irq_src[0] -> PEND=0x01 at +1, irq_out=1 at +2; ack -> irq_out=0, PEND=0x00, SRC=0x8000.
REQ-028 Raise irq_src[5] and [2] together with MASK=0xFF -> cur_src=2; after ack+eoi -> cur_src=5 (fixed); RR_EN with pointer=3 -> 5 first.
REQ-029 Assert irq_out, drop irq_en before ack -> IDLE next cycle, irq_out=0, PEND bit retained; re-enable -> irq_out re-asserts.
REQ-030 Write PEND=0x10 on the same cycle irq_src[4] edge sets it -> PEND[4]=1; later write 0x10 -> PEND[4]=0.
REQ-031 Level source held high across eoi -> re-request 2 cycles after eoi; assert rst in SERVICE -> all registers 0, irq_out=0, busy=0.
REQ-032 Read sel 0x44 and 0x3F -> sr_out=0; eoi in IDLE -> no state change.
